// File: rtl/tennis_pkg.sv
// Shared constants for the tennis scorer: active-low seven-segment codes (gfedcba),
// tens/units digit pairs for point display, the point-FSM state enum and point-index encoding.
package tennis_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_D     = 7'b0100001;

  // {tens, units}
  localparam logic [13:0] PT_00 = {SEG_0, SEG_0};
  localparam logic [13:0] PT_15 = {SEG_1, SEG_5};
  localparam logic [13:0] PT_30 = {SEG_3, SEG_0};
  localparam logic [13:0] PT_40 = {SEG_4, SEG_0};
  localparam logic [13:0] PT_AD = {SEG_A, SEG_D};

  typedef enum logic [2:0] {
    ST_NORMAL,
    ST_DEUCE,
    ST_ADV_P1,
    ST_ADV_P2,
    ST_MATCH_OVER
  } point_state_e;

  typedef logic [1:0] pt_idx_t;
  localparam pt_idx_t IDX_0  = 2'd0;
  localparam pt_idx_t IDX_15 = 2'd1;
  localparam pt_idx_t IDX_30 = 2'd2;
  localparam pt_idx_t IDX_40 = 2'd3;

  function automatic logic [13:0] idx_to_pair(input pt_idx_t idx);
    case (idx)
      IDX_0:   return PT_00;
      IDX_15:  return PT_15;
      IDX_30:  return PT_30;
      default: return PT_40;
    endcase
  endfunction

endpackage

// File: rtl/tennis_match_scorer_seg7_digit.sv
// Single-digit decoder: 4-bit value to active-low gfedcba segments; values above 9 blank.
module seg7_digit
  import tennis_pkg::*;
(
  input  logic [3:0] value_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    case (value_i)
      4'd0: seg_o = SEG_0;
      4'd1: seg_o = SEG_1;
      4'd2: seg_o = SEG_2;
      4'd3: seg_o = SEG_3;
      4'd4: seg_o = SEG_4;
      4'd5: seg_o = SEG_5;
      4'd6: seg_o = SEG_6;
      4'd7: seg_o = SEG_7;
      4'd8: seg_o = SEG_8;
      4'd9: seg_o = SEG_9;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/tennis_match_scorer.sv
// Two-player tennis scorer with deuce/advantage, game counting, match limit and
// post-point input lockout; drives active-low seven-segment digits.
module tennis_match_scorer
  import tennis_pkg::*;
#(
  parameter int LOCKOUT_CYCLES = 12_500_000,
  parameter int GAMES_TO_WIN   = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       p1,
  input  logic       p2,
  output logic [6:0] p1_point_1,
  output logic [6:0] p1_point_0,
  output logic [6:0] p2_point_1,
  output logic [6:0] p2_point_0,
  output logic [6:0] p1_games_seg,
  output logic [6:0] p2_games_seg,
  output logic       p1_game_won,
  output logic       p2_game_won,
  output logic       p1_match_win,
  output logic       p2_match_win,
  output logic       busy
);

  localparam int          LW        = $clog2(LOCKOUT_CYCLES + 1);
  localparam logic [LW-1:0] LOCK_INIT = LW'(LOCKOUT_CYCLES);
  localparam logic [3:0]  GTW       = 4'(GAMES_TO_WIN);

  point_state_e  state_q, state_d;
  pt_idx_t       p1_idx_q, p1_idx_d, p2_idx_q, p2_idx_d;
  logic [3:0]    p1_games_q, p1_games_d, p2_games_q, p2_games_d;
  logic [LW-1:0] lock_q, lock_d;
  logic          p1_won_q, p1_won_d, p2_won_q, p2_won_d;
  logic          p1_match_q, p1_match_d, p2_match_q, p2_match_d;
  logic          accept, p1_game, p2_game;
  logic [13:0]   p1_pair, p2_pair;

  // Exactly one button pressed, lockout idle and match still live.
  assign accept = (lock_q == '0) && !p1_match_q && !p2_match_q &&
                  (state_q != ST_MATCH_OVER) && (p1 ^ p2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_NORMAL;
      p1_idx_q   <= IDX_0;
      p2_idx_q   <= IDX_0;
      p1_games_q <= '0;
      p2_games_q <= '0;
      lock_q     <= '0;
      p1_won_q   <= 1'b0;
      p2_won_q   <= 1'b0;
      p1_match_q <= 1'b0;
      p2_match_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      p1_idx_q   <= p1_idx_d;
      p2_idx_q   <= p2_idx_d;
      p1_games_q <= p1_games_d;
      p2_games_q <= p2_games_d;
      lock_q     <= lock_d;
      p1_won_q   <= p1_won_d;
      p2_won_q   <= p2_won_d;
      p1_match_q <= p1_match_d;
      p2_match_q <= p2_match_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    p1_idx_d   = p1_idx_q;
    p2_idx_d   = p2_idx_q;
    p1_games_d = p1_games_q;
    p2_games_d = p2_games_q;
    p1_match_d = p1_match_q;
    p2_match_d = p2_match_q;
    p1_won_d   = 1'b0;
    p2_won_d   = 1'b0;
    p1_game    = 1'b0;
    p2_game    = 1'b0;
    lock_d     = (lock_q != '0) ? lock_q - LW'(1) : '0;

    if (accept) begin
      lock_d = LOCK_INIT;
      case (state_q)
        ST_NORMAL: begin
          if (p1) begin
            if (p1_idx_q == IDX_40) p1_game = 1'b1;
            else if (p1_idx_q == IDX_30 && p2_idx_q == IDX_40) begin
              p1_idx_d = IDX_40;
              state_d  = ST_DEUCE;
            end else p1_idx_d = p1_idx_q + 2'd1;
          end else begin
            if (p2_idx_q == IDX_40) p2_game = 1'b1;
            else if (p2_idx_q == IDX_30 && p1_idx_q == IDX_40) begin
              p2_idx_d = IDX_40;
              state_d  = ST_DEUCE;
            end else p2_idx_d = p2_idx_q + 2'd1;
          end
        end
        ST_DEUCE:  state_d = p1 ? ST_ADV_P1 : ST_ADV_P2;
        ST_ADV_P1: if (p1) p1_game = 1'b1; else state_d = ST_DEUCE;
        ST_ADV_P2: if (p2) p2_game = 1'b1; else state_d = ST_DEUCE;
        default: ;
      endcase
    end

    if (p1_game || p2_game) begin
      p1_idx_d = IDX_0;
      p2_idx_d = IDX_0;
      state_d  = ST_NORMAL;
    end
    if (p1_game) begin
      p1_games_d = p1_games_q + 4'd1;
      p1_won_d   = 1'b1;
      if (p1_games_d == GTW) begin
        p1_match_d = 1'b1;
        state_d    = ST_MATCH_OVER;
      end
    end
    if (p2_game) begin
      p2_games_d = p2_games_q + 4'd1;
      p2_won_d   = 1'b1;
      if (p2_games_d == GTW) begin
        p2_match_d = 1'b1;
        state_d    = ST_MATCH_OVER;
      end
    end
  end

  // Deuce/advantage override the raw index display; both indices sit at 40 there.
  always_comb begin
    p1_pair = idx_to_pair(p1_idx_q);
    p2_pair = idx_to_pair(p2_idx_q);
    case (state_q)
      ST_DEUCE: begin
        p1_pair = PT_40;
        p2_pair = PT_40;
      end
      ST_ADV_P1: begin
        p1_pair = PT_AD;
        p2_pair = PT_40;
      end
      ST_ADV_P2: begin
        p1_pair = PT_40;
        p2_pair = PT_AD;
      end
      default: ;
    endcase
  end

  assign {p1_point_1, p1_point_0} = p1_pair;
  assign {p2_point_1, p2_point_0} = p2_pair;
  assign p1_game_won  = p1_won_q;
  assign p2_game_won  = p2_won_q;
  assign p1_match_win = p1_match_q;
  assign p2_match_win = p2_match_q;
  assign busy         = (lock_q != '0);

  seg7_digit u_p1_games (.value_i(p1_games_q), .seg_o(p1_games_seg));
  seg7_digit u_p2_games (.value_i(p2_games_q), .seg_o(p2_games_seg));

endmodule

// File: tb/tb_tennis_match_scorer.sv
// Directed bench for tennis_match_scorer with a short lockout and a two-game match.
module tb_tennis_match_scorer;

  localparam logic [6:0]  E0   = 7'b1000000;
  localparam logic [6:0]  E1   = 7'b1111001;
  localparam logic [6:0]  E2   = 7'b0100100;
  localparam logic [13:0] E00  = {7'b1000000, 7'b1000000};
  localparam logic [13:0] E15  = {7'b1111001, 7'b0010010};
  localparam logic [13:0] E30  = {7'b0110000, 7'b1000000};
  localparam logic [13:0] E40  = {7'b0011001, 7'b1000000};
  localparam logic [13:0] EAD  = {7'b0001000, 7'b0100001};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       p1 = 1'b0;
  logic       p2 = 1'b0;
  logic [6:0] p1_point_1, p1_point_0, p2_point_1, p2_point_0;
  logic [6:0] p1_games_seg, p2_games_seg;
  logic       p1_game_won, p2_game_won, p1_match_win, p2_match_win, busy;
  logic [13:0] p1_pair, p2_pair;

  int n_cmp = 0;
  int n_err = 0;

  assign p1_pair = {p1_point_1, p1_point_0};
  assign p2_pair = {p2_point_1, p2_point_0};

  tennis_match_scorer #(.LOCKOUT_CYCLES(4), .GAMES_TO_WIN(2)) dut (
    .clk(clk), .rst(rst), .p1(p1), .p2(p2),
    .p1_point_1(p1_point_1), .p1_point_0(p1_point_0),
    .p2_point_1(p2_point_1), .p2_point_0(p2_point_0),
    .p1_games_seg(p1_games_seg), .p2_games_seg(p2_games_seg),
    .p1_game_won(p1_game_won), .p2_game_won(p2_game_won),
    .p1_match_win(p1_match_win), .p2_match_win(p2_match_win),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk7(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk14(input string tag, input logic [13:0] obs, input logic [13:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_pts(input string tag, input logic [13:0] e1, input logic [13:0] e2);
    chk14({tag, " p1"}, p1_pair, e1);
    chk14({tag, " p2"}, p2_pair, e2);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Hold the buttons across exactly one rising edge; returns on the following falling edge.
  task automatic press(input logic a, input logic b);
    @(negedge clk);
    p1 = a;
    p2 = b;
    @(negedge clk);
    p1 = 1'b0;
    p2 = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 20; i++) begin
      if (!busy) break;
      @(negedge clk);
    end
    chk1("lockout_expired", busy, 1'b0);
  endtask

  task automatic pt(input logic a, input logic b);
    press(a, b);
    wait_idle();
  endtask

  initial begin
    // Reset state
    do_reset();
    chk_pts("reset", E00, E00);
    chk7("reset p1 games", p1_games_seg, E0);
    chk7("reset p2 games", p2_games_seg, E0);
    chk1("reset busy", busy, 1'b0);
    chk1("reset p1 match", p1_match_win, 1'b0);
    chk1("reset p2 match", p2_match_win, 1'b0);

    // First point and lockout window
    press(1'b1, 1'b0);
    chk_pts("first point", E15, E00);
    for (int i = 0; i < 4; i++) begin
      chk1("busy during lockout", busy, 1'b1);
      p1 = (i == 1);
      @(negedge clk);
    end
    p1 = 1'b0;
    chk1("busy after lockout", busy, 1'b0);
    chk_pts("press ignored in lockout", E15, E00);

    // Clean game to P1
    pt(1'b1, 1'b0);
    chk_pts("p1 30", E30, E00);
    pt(1'b1, 1'b0);
    chk_pts("p1 40", E40, E00);
    press(1'b1, 1'b0);
    chk1("p1 game pulse", p1_game_won, 1'b1);
    chk1("p2 no pulse", p2_game_won, 1'b0);
    chk7("p1 games one", p1_games_seg, E1);
    chk_pts("after clean game", E00, E00);
    @(negedge clk);
    chk1("p1 pulse one cycle", p1_game_won, 1'b0);
    wait_idle();

    // Both buttons together: nothing accepted
    press(1'b1, 1'b1);
    chk1("both high busy", busy, 1'b0);
    chk_pts("both high", E00, E00);

    // Deuce / advantage
    do_reset();
    pt(1'b1, 1'b0); pt(1'b0, 1'b1);
    pt(1'b1, 1'b0); pt(1'b0, 1'b1);
    pt(1'b1, 1'b0);
    chk_pts("40-30", E40, E30);
    pt(1'b0, 1'b1);
    chk_pts("deuce", E40, E40);
    pt(1'b0, 1'b1);
    chk_pts("adv p2", E40, EAD);
    pt(1'b1, 1'b0);
    chk_pts("back to deuce", E40, E40);
    pt(1'b1, 1'b0);
    chk_pts("adv p1", EAD, E40);
    press(1'b1, 1'b0);
    chk1("deuce game pulse", p1_game_won, 1'b1);
    chk7("deuce game p1 games", p1_games_seg, E1);
    chk7("deuce game p2 games", p2_games_seg, E0);
    chk_pts("after deuce game", E00, E00);
    chk1("no match after one game", p1_match_win, 1'b0);
    wait_idle();

    // Match to P2 (two games)
    do_reset();
    repeat (4) pt(1'b0, 1'b1);
    chk7("p2 games one", p2_games_seg, E1);
    chk1("p2 no match yet", p2_match_win, 1'b0);
    repeat (3) pt(1'b0, 1'b1);
    press(1'b0, 1'b1);
    chk1("p2 second game pulse", p2_game_won, 1'b1);
    chk1("p2 match win", p2_match_win, 1'b1);
    chk7("p2 games two", p2_games_seg, E2);
    wait_idle();
    press(1'b1, 1'b0);
    chk1("match over busy", busy, 1'b0);
    chk_pts("match over points", E00, E00);
    press(1'b0, 1'b1);
    chk7("match over p1 games", p1_games_seg, E0);
    chk7("match over p2 games", p2_games_seg, E2);
    chk1("match sticky", p2_match_win, 1'b1);
    chk1("p1 no match", p1_match_win, 1'b0);

    // Async reset mid-lockout at advantage P1
    do_reset();
    repeat (4) pt(1'b1, 1'b0);
    repeat (3) begin
      pt(1'b1, 1'b0);
      pt(1'b0, 1'b1);
    end
    press(1'b1, 1'b0);
    chk_pts("pre-reset adv p1", EAD, E40);
    chk1("pre-reset busy", busy, 1'b1);
    #3 rst = 1'b1;
    #1;
    chk_pts("async reset", E00, E00);
    chk7("async reset p1 games", p1_games_seg, E0);
    chk1("async reset busy", busy, 1'b0);
    chk1("async reset pulse", p1_game_won, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    press(1'b1, 1'b0);
    chk_pts("first point after reset", E15, E00);
    chk1("busy after reset point", busy, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/tennis_match_scorer.md
Name: tennis_match_scorer

Overview:
Two-player tennis scoring engine driving active-low 7-segment displays. It is the parametrised successor to the fixed 0/15/30/40 point counter. It adds deuce/advantage handling, a per-player game counter, a configurable games-to-win match limit, and a parametrised input lockout that replaces the fixed 250 ms flag controller. It sits between the player push-button inputs and the board's seven-segment digit drivers.

Parameters:
LOCKOUT_CYCLES, 12_500_000, cycles after an accepted point during which p1/p2 are ignored (250 ms at 50 MHz); must be >= 1.
GAMES_TO_WIN, 6, games needed to win the match; range 1..9 (single display digit).

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
p1  input  1  player 1 scores (active-high level, already synchronised)
p2  input  1  player 2 scores (active-high level, already synchronised)
p1_point_1  output  7  P1 point tens digit, segments gfedcba, active-low
p1_point_0  output  7  P1 point units digit
p2_point_1  output  7  P2 point tens digit
p2_point_0  output  7  P2 point units digit
p1_games_seg  output  7  P1 games-won digit
p2_games_seg  output  7  P2 games-won digit
p1_game_won  output  1  one-cycle pulse when P1 takes a game
p2_game_won  output  1  one-cycle pulse when P2 takes a game
p1_match_win  output  1  sticky until reset: P1 won the match
p2_match_win  output  1  sticky until reset: P2 won the match
busy  output  1  high while lockout counter is non-zero

Behaviour:
- Reset (async, active-high): point counts 0/0, advantage none, games 0/0, lockout counter 0, pulses and match flags 0. Displays show "00"/"00" for points and "0"/"0" for games.
- Point acceptance: a point is accepted on a clk edge when the lockout counter is 0, no match flag is set, and {p1,p2} is 2'b10 (P1) or 2'b01 (P2).
  - Both high or both low: nothing accepted; counter stays 0.
  - On acceptance the lockout counter loads LOCKOUT_CYCLES. It then decrements every cycle to 0. Counter width is $clog2(LOCKOUT_CYCLES+1).
  - A held button scores again once the lockout expires; no edge detection.
- Point FSM states: NORMAL, DEUCE, ADV_P1, ADV_P2, MATCH_OVER. Per-player point index 0..3 maps to 0/15/30/40.
  - NORMAL, scorer index 3, opponent < 3: game to scorer.
  - NORMAL, scorer index 2, opponent index 3: scorer goes to 3; -> DEUCE.
  - NORMAL, otherwise: scorer index +1.
  - DEUCE: scorer -> ADV_scorer.
  - ADV_X, X scores: game to X.
  - ADV_X, opponent scores: -> DEUCE.
- Game won:
  - Both point indices reset to 0 and state returns to NORMAL, on the same edge.
  - The winner's games count increments; the matching *_game_won pulse is high for exactly the following cycle.
  - If the new games count equals GAMES_TO_WIN: set the matching *_match_win (sticky) and go to MATCH_OVER.
  - MATCH_OVER ignores all inputs until rst. Final game count stays displayed; points show "00"/"00".
- Display decode: combinational from registered state, so it reflects the update in the cycle after the accepting edge.
  - Point indices 0..3 display "00", "15", "30", "40".
  - DEUCE shows "40" on both players.
  - ADV_X shows "AD" on X (A=7'b0001000, d=7'b0100001); the opponent shows "40".
  - Games digits use the standard 0..9 active-low codes.
- Latency: accepting edge -> state updated; *_game_won pulse asserts for one cycle after that edge.
- rst asserted mid-lockout or mid-game clears everything immediately, regardless of clk.

Decomposition:
- Package tennis_pkg holds:
  - active-low 7-seg constants BLANK, 0..9, A, d;
  - 14-bit point pairs _00, _15, _30, _40, _AD;
  - the point-FSM state enum;
  - the point-index encoding.
- One sub-module: seg7_digit (4-bit value -> 7-bit active-low segments), instantiated for both games digits. The point-pair decode stays inline.

Test Plan:
- LOCKOUT_CYCLES=4: after rst, p1 held high 1 cycle -> p1_point_1/0 = ONE/FIVE, busy high 4 cycles; p1 pulse during busy -> ignored, still "15".
- P1 scores 4 clean points -> p1_game_won pulses 1 cycle, p1_games_seg=ONE, both players' points "00".
- Reach 40-40 (3 each) -> DEUCE; P2 scores -> p2 "AD", p1 "40"; P1 scores -> both "40"; P1, P1 -> P1 takes game, games 1-0.
- p1 and p2 both high with lockout clear -> no point, busy stays 0.
- GAMES_TO_WIN=2: P2 wins 2 games -> p2_match_win=1 sticky; further p1/p2 pulses change nothing; p2_games_seg=TWO.
- Assert rst mid-lockout at advantage P1 -> all outputs return to reset values asynchronously; first point after release accepted immediately.
